// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that merges several bus masters onto the single memory port.
// Optional ARB_TIMEOUT_EN adds a BUSY-state watchdog that releases the bus after TIMEOUT cycles.
module mem_bus_arbiter #(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_request,
  input  logic [N_MASTERS-1:0]          m_mode,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_locator,
  input  logic [N_MASTERS*DATA_W-1:0]   m_write,
  output logic [N_MASTERS-1:0]          m_response,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          mem_request,
  output logic                          mem_mode,
  output logic [ADDR_W-1:0]             mem_locator,
  output logic [DATA_W-1:0]             mem_write,
  input  logic                          mem_response,
  output logic                          timeout_err
);

  localparam int unsigned IdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  // last_q doubles as the owner index while BUSY/RELEASE, since it only moves on a grant.
  logic [IdxW-1:0]      last_q, last_d;

  logic                 hit;
  logic [IdxW-1:0]      pick;
  logic                 expire;
  logic                 suppress_rsp;

  always_comb begin
    int unsigned cand;
    hit  = 1'b0;
    pick = last_q;
    cand = 0;
    for (int unsigned k = 1; k <= N_MASTERS; k++) begin
      cand = (int'(last_q) + k) % N_MASTERS;
      if (!hit && m_request[cand]) begin
        hit  = 1'b1;
        pick = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          grant_d = N_MASTERS'(1) << pick;
          last_d  = pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (mem_response || expire) state_d = StRelease;
      end
      StRelease: begin
        if (!m_request[last_q]) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] cnt_q;
  logic            tout_q;
  logic            err_q;

  // Counter is held at zero in IDLE, so it is always zero on the first BUSY cycle.
  assign expire = (state_q == StBusy) && !mem_response && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= expire;
      if (state_q == StIdle) begin
        cnt_q <= '0;
      end else if (state_q == StBusy) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (expire) begin
        tout_q <= 1'b1;
      end else if (state_q == StIdle) begin
        tout_q <= 1'b0;
      end
    end
  end

  assign suppress_rsp = tout_q;
  assign timeout_err  = err_q && !reset;
`else
  assign expire       = 1'b0;
  assign suppress_rsp = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // Outputs are gated by reset so nothing leaks out during the reset cycle itself.
  logic busy;
  logic fwd;
  assign busy = (state_q == StBusy) && !reset;
  assign fwd  = !reset && ((state_q == StBusy) || ((state_q == StRelease) && !suppress_rsp));

  always_comb begin
    mem_request = busy;
    mem_mode    = 1'b0;
    mem_locator = '0;
    mem_write   = '0;
    if (busy) begin
      mem_mode    = m_mode[last_q];
      mem_locator = m_locator[last_q*ADDR_W +: ADDR_W];
      mem_write   = m_write[last_q*DATA_W +: DATA_W];
    end
  end

  assign m_response = fwd ? (grant_q & {N_MASTERS{mem_response}}) : '0;
  assign grant      = reset ? '0 : grant_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sits directly upstream of `memory`. Replaces the wired-OR merge of loader, cpu and reader request/mode/locator/write signals with a registered, round-robin arbiter.
- Grants exactly one master per transaction and drives the single memory port.
- Routes `response_flag` back only to the granted master.
- Read data stays broadcast on the shared `read_bus`; it does not pass through this block.

Parameters:
- N_MASTERS, 3, number of requesting masters (index 0 = loader, 1 = cpu, 2 = reader).
- ADDR_W, 16, locator width.
- DATA_W, 16, write data width.
- TIMEOUT, 255, cycles to wait for a memory response before forced release (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- m_request  in  N_MASTERS  per-master request flag.
- m_mode  in  N_MASTERS  per-master mode flag (1 = write, 0 = read).
- m_locator  in  N_MASTERS*ADDR_W  per-master address, master i at bits [i*ADDR_W +: ADDR_W].
- m_write  in  N_MASTERS*DATA_W  per-master write data, same packing.
- m_response  out  N_MASTERS  per-master response flag.
- grant  out  N_MASTERS  one-hot current owner; all zero when idle.
- mem_request  out  1  to memory `request_flag`.
- mem_mode  out  1  to memory `mode_flag`.
- mem_locator  out  ADDR_W  to memory `locator`.
- mem_write  out  DATA_W  to memory `write_bus`.
- mem_response  in  1  from memory `response_flag`.
- timeout_err  out  1  one-cycle pulse on forced release (optional feature only; tied 0 otherwise).

Behaviour:
- Memory handshake:
  - Master holds request, mode, locator and write stable until it sees its response.
  - Memory raises `mem_response` for one or more cycles when the access completes.
  - Master then drops its request.
- States: IDLE, BUSY, RELEASE. State register, grant register and `last` pointer are all registered.
- IDLE:
  - Each cycle, scan `m_request` round-robin starting at (last+1) mod N_MASTERS.
  - On a hit at edge t: grant = one-hot(i), last = i, go to BUSY. `mem_request` is high from t+1, so latency from request to memory request is one cycle.
  - No requests: stay in IDLE.
- BUSY:
  - `mem_request` = 1.
  - `mem_mode`, `mem_locator` and `mem_write` are muxed combinationally from the granted master.
  - `m_response[g] = mem_response`; all other `m_response` bits are 0.
  - On `mem_response` = 1, go to RELEASE at the next edge.
  - Master dropping its request while in BUSY is ignored: grant is held until response.
- RELEASE:
  - `mem_request` = 0, all mem_* data outputs 0, `m_response[g]` = `mem_response` (passes any trailing response).
  - Stay while `m_request[g]` = 1.
  - When it drops, clear grant and go to IDLE.
  - Re-arbitration starts in IDLE the following cycle, so minimum spacing between transactions is 3 cycles.
- Outputs when not in BUSY: `mem_mode`, `mem_locator` and `mem_write` are all zero. This keeps compatibility with any remaining wired-OR.
- Fairness: `last` only advances on a grant. With all N masters requesting continuously, each is served once per N transactions in order 0,1,2,0,…
- Reset (synchronous, including mid-transaction):
  - At the next edge, state = IDLE, grant = 0, last = N_MASTERS-1 (so master 0 has first priority).
  - All outputs 0. No response is forwarded during or after reset.
- Single master: re-grant to the same master is allowed after its RELEASE completes.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - 8-bit-minimum counter, cleared on entering BUSY and incremented each BUSY cycle.
  - If it reaches TIMEOUT with no `mem_response`, go to RELEASE, pulse `timeout_err` for one cycle and forward no response to the master.
  - The master must still drop its request to exit RELEASE.
- Undefined: no counter; BUSY waits indefinitely; `timeout_err` is constant 0.

Test Plan:
- Reset: hold reset 2 cycles with m_request=3'b111 → grant=0, mem_request=0, all outputs 0. First grant after release is master 0.
- Single read: master 1 requests at t, mode=0, locator=16'h0040 → mem_request=1 and mem_locator=16'h0040 at t+1. Memory response at t+4 → m_response=3'b010 at t+4, mem_request=0 at t+5.
- Round robin: all three request continuously, memory responds 2 cycles after each mem_request → grant sequence 001, 010, 100, 001.
- Write pass-through: master 0 mode=1, locator=16'h0010, write=16'hBEEF → mem_mode=1, mem_write=16'hBEEF. Master 2's nonzero write data must not appear on mem_write.
- Reset mid-transaction: assert reset in BUSY with mem_response pending → next cycle grant=0, mem_request=0. The later mem_response pulse produces m_response=0.
- ARB_TIMEOUT_EN, TIMEOUT=4: master 2 requests, no response → timeout_err pulses once 4 cycles after BUSY entry, m_response stays 0. Grant clears after master 2 drops its request.
